// File: rtl/clock_enable_divider_multi.sv
// Multi-channel clock-enable divider: each channel divides i_ce_mhz by its own
// programmable divisor, with shadow reload applied on wrap or while disabled.
module clock_enable_divider_multi #(
    parameter int par_channels    = 4,
    parameter int par_div_width   = 16,
    parameter int par_div_default = 1000,
    localparam int sel_width      = (par_channels > 1) ? $clog2(par_channels) : 1
) (
    input  logic                     i_clk_mhz,
    input  logic                     i_rst_mhz,
    input  logic                     i_ce_mhz,
    input  logic [par_channels-1:0]  i_ch_enable,
    input  logic [par_channels-1:0]  i_oneshot,
    input  logic                     i_div_load,
    input  logic [sel_width-1:0]     i_div_sel,
    input  logic [par_div_width-1:0] i_div_value,
    output logic [par_channels-1:0]  o_ce_div,
    output logic [par_channels-1:0]  o_done,
    output logic [par_channels-1:0]  o_load_pending
);

    localparam logic [par_div_width-1:0] div_reset = par_div_width'(par_div_default);

    logic [par_div_width-1:0] cnt_q     [par_channels];
    logic [par_div_width-1:0] div_act_q [par_channels];
    logic [par_div_width-1:0] div_shd_q [par_channels];
    logic [par_div_width-1:0] term_cnt  [par_channels];
    logic [par_channels-1:0]  ce_q;
    logic [par_channels-1:0]  done_q;
    logic [par_channels-1:0]  pend_q;
    logic [par_channels-1:0]  hold;
    logic [par_channels-1:0]  wrap;
    logic [par_channels-1:0]  apply;
    logic [par_channels-1:0]  load_hit;

    // Divisors 0 and 1 share a terminal count of 0, i.e. a pulse on every source CE.
    always_comb begin
        for (int ch = 0; ch < par_channels; ch++) begin
            term_cnt[ch] = '0;
            if (div_act_q[ch] > par_div_width'(1))
                term_cnt[ch] = div_act_q[ch] - par_div_width'(1);
            hold[ch]     = i_oneshot[ch] & done_q[ch];
            wrap[ch]     = i_ch_enable[ch] & ~hold[ch] & i_ce_mhz & (cnt_q[ch] == term_cnt[ch]);
            apply[ch]    = wrap[ch] | ~i_ch_enable[ch];
            load_hit[ch] = i_div_load & (int'(i_div_sel) == ch);
        end
    end

    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            ce_q   <= '0;
            done_q <= '0;
            pend_q <= '0;
            for (int ch = 0; ch < par_channels; ch++) begin
                cnt_q[ch]     <= '0;
                div_act_q[ch] <= div_reset;
                div_shd_q[ch] <= div_reset;
            end
        end else begin
            for (int ch = 0; ch < par_channels; ch++) begin
                if (!i_ch_enable[ch]) begin
                    cnt_q[ch]  <= '0;
                    ce_q[ch]   <= 1'b0;
                    done_q[ch] <= 1'b0;
                end else if (hold[ch]) begin
                    ce_q[ch] <= 1'b0;
                end else if (wrap[ch]) begin
                    cnt_q[ch] <= '0;
                    ce_q[ch]  <= 1'b1;
                    if (i_oneshot[ch])
                        done_q[ch] <= 1'b1;
                end else if (i_ce_mhz) begin
                    cnt_q[ch] <= cnt_q[ch] + par_div_width'(1);
                    ce_q[ch]  <= 1'b0;
                end else begin
                    ce_q[ch] <= 1'b0;
                end

                // Apply reads the shadow before a same-cycle load overwrites it.
                if (apply[ch])
                    div_act_q[ch] <= div_shd_q[ch];
                if (load_hit[ch]) begin
                    div_shd_q[ch] <= i_div_value;
                    pend_q[ch]    <= 1'b1;
                end else if (apply[ch]) begin
                    pend_q[ch] <= 1'b0;
                end
            end
        end
    end

    assign o_ce_div       = ce_q;
    assign o_done         = done_q;
    assign o_load_pending = pend_q;

endmodule

// File: tb/tb_clock_enable_divider_multi.sv
// Scoreboarded random/directed bench for clock_enable_divider_multi; a second
// 3-channel instance covers the out-of-range divisor select.
module tb_clock_enable_divider_multi;

    localparam int NCH = 4;
    localparam int DW  = 16;

    typedef struct packed {
        logic [NCH-1:0] ce;
        logic [NCH-1:0] done;
        logic [NCH-1:0] pend;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ce_in = 1'b0;
    logic [NCH-1:0] en = '0;
    logic [NCH-1:0] os = '0;
    logic           ld = 1'b0;
    logic [1:0]     sel = '0;
    logic [DW-1:0]  val = '0;
    logic [NCH-1:0] ce_div, done, pend;

    logic           b_rst = 1'b1;
    logic           b_ce = 1'b0;
    logic [2:0]     b_en = '0;
    logic [2:0]     b_os = '0;
    logic           b_ld = 1'b0;
    logic [1:0]     b_sel = '0;
    logic [7:0]     b_val = '0;
    logic [2:0]     b_ce_div, b_done, b_pend;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int pulses0  = 0;
    exp_t q[$];

    // Reference: per channel, how many qualifying source CEs have been seen
    // since the last pulse, plus the divisor pair and the status flags.
    int m_seen[NCH];
    int m_act[NCH];
    int m_shd[NCH];
    bit m_ce[NCH];
    bit m_done[NCH];
    bit m_pend[NCH];

    always #5 clk = ~clk;

    clock_enable_divider_multi #(.par_channels(NCH), .par_div_width(DW), .par_div_default(1000)) dut (
        .i_clk_mhz(clk), .i_rst_mhz(rst), .i_ce_mhz(ce_in), .i_ch_enable(en),
        .i_oneshot(os), .i_div_load(ld), .i_div_sel(sel), .i_div_value(val),
        .o_ce_div(ce_div), .o_done(done), .o_load_pending(pend));

    clock_enable_divider_multi #(.par_channels(3), .par_div_width(8), .par_div_default(2)) dut_b (
        .i_clk_mhz(clk), .i_rst_mhz(b_rst), .i_ce_mhz(b_ce), .i_ch_enable(b_en),
        .i_oneshot(b_os), .i_div_load(b_ld), .i_div_sel(b_sel), .i_div_value(b_val),
        .o_ce_div(b_ce_div), .o_done(b_done), .o_load_pending(b_pend));

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cycle, got, want);
        end
    endtask

    task automatic model_update();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            int  period;
            bit  pulsed;
            period = (m_act[c] < 1) ? 1 : m_act[c];
            pulsed = 1'b0;
            if (rst) begin
                m_seen[c] = 0; m_act[c] = 1000; m_shd[c] = 1000;
                m_ce[c] = 0; m_done[c] = 0; m_pend[c] = 0;
                continue;
            end
            m_ce[c] = 0;
            if (!en[c]) begin
                m_seen[c] = 0;
                m_done[c] = 0;
            end else if (!(os[c] && m_done[c]) && ce_in) begin
                m_seen[c] = m_seen[c] + 1;
                if (m_seen[c] >= period) begin
                    m_seen[c] = 0;
                    pulsed    = 1'b1;
                    m_ce[c]   = 1;
                    if (os[c]) m_done[c] = 1;
                end
            end
            if (pulsed || !en[c]) begin
                m_act[c]  = m_shd[c];
                m_pend[c] = 0;
            end
            if (ld && sel == c) begin
                m_shd[c]  = val;
                m_pend[c] = 1;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            e.ce[c] = m_ce[c]; e.done[c] = m_done[c]; e.pend[c] = m_pend[c];
        end
        q.push_back(e);
    endtask

    // Inputs are held from one falling edge to the next; load is a one-cycle strobe.
    task automatic step();
        model_update();
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int ch, input int v);
        ld = 1'b1; sel = 2'(ch); val = DW'(v);
        step();
    endtask

    always @(posedge clk) begin
        #1;
        cycle++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("ce_div", int'(ce_div), int'(e.ce));
            check("done", int'(done), int'(e.done));
            check("load_pending", int'(pend), int'(e.pend));
            if (ce_div[0] === 1'b1) pulses0++;
        end
    end

    initial begin
        int bp;
        @(negedge clk);
        rst = 1'b1; step(); step();
        rst = 1'b0;

        // ch0 default 1000 with continuous source CE
        en = 4'b0001; ce_in = 1'b1; pulses0 = 0;
        run(3000);
        check("ch0_pulses_3000", pulses0, 3);
        en = '0; step();

        // ch1 divisor 3 loaded while disabled, source CE 1 in 4
        load(1, 3); step();
        en = 4'b0010;
        for (int i = 0; i < 48; i++) begin
            ce_in = (i % 4 == 3); step();
        end
        en = '0; step();

        // ch2 divisor 10, then 4 loaded mid-count
        load(2, 10); step();
        en = 4'b0100; ce_in = 1'b1;
        run(5);
        load(2, 4);
        run(20);
        en = '0; step();

        // ch3 one-shot divisor 5, re-armed by dropping enable
        load(3, 5); step();
        os = 4'b1000; en = 4'b1000;
        run(12);
        en = '0; step();
        en = 4'b1000; run(12);
        en = '0; os = '0; step();

        // divisor 0 then 1 on ch0: pulse every cycle
        load(0, 0); step();
        en = 4'b0001; pulses0 = 0;
        run(8);
        check("ch0_div0_pulses", pulses0, 8);
        load(0, 1); run(6);

        // reset mid-count with a load pending
        en = 4'b0101; load(2, 9); step(); step();
        run(4); load(2, 3);
        rst = 1'b1; step();
        rst = 1'b0; run(1005);

        // randomized traffic with small divisors
        for (int i = 0; i < 2500; i++) begin
            rst   = ($urandom_range(299, 0) == 0);
            ce_in = ($urandom_range(2, 0) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(24, 0) == 0) en[c] = ~en[c];
                if ($urandom_range(39, 0) == 0) os[c] = ~os[c];
            end
            if ($urandom_range(6, 0) == 0) begin
                ld = 1'b1; sel = 2'($urandom_range(3, 0)); val = DW'($urandom_range(9, 0));
            end
            step();
        end
        rst = 1'b0;

        // out-of-range select on a 3-channel instance is ignored
        b_rst = 1'b1; @(negedge clk);
        b_rst = 1'b0; b_en = 3'b111; b_ce = 1'b1;
        b_ld = 1'b1; b_sel = 2'd3; b_val = 8'd7;
        bp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b_ld = 1'b0;
            if (i == 0) check("oor_pending", int'(b_pend), 0);
            if (b_ce_div[0]) bp++;
        end
        check("oor_ch0_pulses", bp, 5);
        check("oor_pending_end", int'(b_pend), 0);

        @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
